fw_ip2_core: RTL and testbench

// - Firmware IP #2 of the CMS pixel test system. Sits between common_sw_to_fw_side
//   (op-code strobes plus a 24-bit write word) and common_fw_to_dut_side (chip pins).
// - Holds a software-writable static configuration register, config_static_0.
// - Generates the analog bunch-crossing clock fw_bxclk_ana and a phase-shifted

---
 rtl/fw_ip2_pkg.sv | 12 +
 rtl/fw_ip2_bxclk_gen.sv | 73 +++++++
 rtl/fw_ip2_core.sv | 98 +++++++++
 tb/tb_fw_ip2_core.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_ip2_pkg.sv
// Shared constants for firmware IP #2: config_static_0 field positions and bus widths.
package fw_ip2_pkg;
  localparam int DATA_W    = 32;
  localparam int WRITE_W   = 24;
  localparam int PERIOD_LSB = 0;
  localparam int PERIOD_W   = 6;
  localparam int DELAY_LSB  = 6;
  localparam int DELAY_W    = 5;
  localparam int SIGN_BIT   = 11;
  localparam int SPS_BIT    = 12;
  localparam int SYNC_W     = 5;
endpackage

// File: rtl/fw_ip2_bxclk_gen.sv
// Bunch-crossing clock generator: fw_bxclk_ana from a 1..P counter, and a phase-shifted
// fw_bxclk from a second counter that is offset by the clamped delay.
module fw_ip2_bxclk_gen
  import fw_ip2_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DELAY_W-1:0]  delay,
  input  logic                sign,
  output logic                bxclk_ana,
  output logic                bxclk,
  output logic                run
);

  logic [PERIOD_W-1:0] half_p, deff, start2, cnt, cnt2, period_q;
  logic [DELAY_W-1:0]  delay_q;
  logic                sign_q, changed;

  function automatic logic [PERIOD_W-1:0] sat_delay(input logic [DELAY_W-1:0] d,
                                                    input logic [PERIOD_W-1:0] lim);
    if (PERIOD_W'(d) > lim) return lim;
    return PERIOD_W'(d);
  endfunction

  function automatic logic high_phase(input logic [PERIOD_W-1:0] c,
                                      input logic [PERIOD_W-1:0] h);
    return (c != '0) && (c <= h);
  endfunction

  assign half_p  = period >> 1;
  assign deff    = sat_delay(delay, half_p);
  assign run     = (period >= PERIOD_W'(2));
  assign changed = (period != period_q) || (delay != delay_q) || (sign != sign_q);

  // Second counter starts +Deff (lead) or -Deff mod P (lag) relative to cnt = 1.
  always_comb begin
    start2 = PERIOD_W'(1);
    if (sign)
      start2 = PERIOD_W'(1) + deff;
    else if (deff != '0)
      start2 = period + PERIOD_W'(1) - deff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cnt2      <= '0;
      period_q  <= '0;
      delay_q   <= '0;
      sign_q    <= 1'b0;
      bxclk_ana <= 1'b0;
      bxclk     <= 1'b0;
    end else begin
      period_q  <= period;
      delay_q   <= delay;
      sign_q    <= sign;
      bxclk_ana <= high_phase(cnt, half_p);
      bxclk     <= high_phase(cnt2, half_p);
      if (!run) begin
        cnt  <= '0;
        cnt2 <= '0;
      end else if (changed || cnt == '0) begin
        cnt  <= PERIOD_W'(1);
        cnt2 <= start2;
      end else begin
        cnt  <= (cnt  >= period) ? PERIOD_W'(1) : cnt  + PERIOD_W'(1);
        cnt2 <= (cnt2 >= period) ? PERIOD_W'(1) : cnt2 + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/fw_ip2_core.sv
// Firmware IP #2 core: config_static_0 register, read-back mux, status word and
// DUT pin drive, with the bunch-crossing clocks from fw_ip2_bxclk_gen.
module fw_ip2_core
  import fw_ip2_pkg::*;
(
  input  logic               fw_pl_clk1,
  input  logic               fw_rst,
  input  logic               fw_dev_id_enable,
  input  logic               fw_op_code_w_reset,
  input  logic               fw_op_code_w_cfg_static_0,
  input  logic               fw_op_code_r_cfg_static_0,
  input  logic               fw_op_code_w_cfg_array_0,
  input  logic               fw_op_code_r_cfg_array_0,
  input  logic               fw_op_code_w_cfg_array_1,
  input  logic               fw_op_code_r_cfg_array_1,
  input  logic               fw_op_code_r_data_array_0,
  input  logic               fw_op_code_r_data_array_1,
  input  logic               fw_op_code_w_execute,
  input  logic               fw_op_code_r_status,
  input  logic [WRITE_W-1:0] sw_write24_0,
  output logic [DATA_W-1:0]  fw_read_data32,
  output logic [DATA_W-1:0]  fw_read_status32,
  output logic               fw_super_pixel_sel,
  output logic               fw_config_clk,
  output logic               fw_reset_not,
  output logic               fw_config_in,
  output logic               fw_config_load,
  output logic               fw_bxclk_ana,
  output logic               fw_bxclk,
  output logic               fw_vin_test_trig_out,
  output logic               fw_scan_in,
  output logic               fw_scan_load,
  input  logic               fw_config_out,
  input  logic               fw_scan_out,
  input  logic               fw_dnn_output_0,
  input  logic               fw_dnn_output_1,
  input  logic               fw_dn_event_toggle
);

  logic              srst, reserved_op, run;
  logic [DATA_W-1:0] config_static_0;
  logic [SYNC_W-1:0] sync1, sync2;

  assign srst = fw_rst | (fw_dev_id_enable & fw_op_code_w_reset);

  // Reserved op-codes are decoded only so a read of them lands on the zero branch.
  assign reserved_op = fw_op_code_w_cfg_array_0 | fw_op_code_r_cfg_array_0 |
                       fw_op_code_w_cfg_array_1 | fw_op_code_r_cfg_array_1 |
                       fw_op_code_r_data_array_0 | fw_op_code_r_data_array_1 |
                       fw_op_code_w_execute;

  assign fw_read_status32 = {26'h0, sync2, run};

  assign fw_config_clk        = 1'b0;
  assign fw_config_in         = 1'b0;
  assign fw_config_load       = 1'b0;
  assign fw_scan_in           = 1'b0;
  assign fw_scan_load         = 1'b0;
  assign fw_vin_test_trig_out = 1'b0;

  always_ff @(posedge fw_pl_clk1) begin
    fw_reset_not <= ~srst;
    if (srst) begin
      config_static_0    <= '0;
      fw_read_data32     <= '0;
      fw_super_pixel_sel <= 1'b0;
      sync1              <= '0;
      sync2              <= '0;
    end else begin
      sync1 <= {fw_dn_event_toggle, fw_dnn_output_1, fw_dnn_output_0, fw_scan_out, fw_config_out};
      sync2 <= sync1;
      fw_super_pixel_sel <= config_static_0[SPS_BIT];
      if (fw_dev_id_enable && fw_op_code_w_cfg_static_0)
        config_static_0 <= {8'h00, sw_write24_0};
      // Read mux samples the pre-write register, so write+read returns the old value.
      if (fw_dev_id_enable && fw_op_code_r_cfg_static_0)
        fw_read_data32 <= config_static_0;
      else if (fw_dev_id_enable && fw_op_code_r_status)
        fw_read_data32 <= fw_read_status32;
      else if (fw_dev_id_enable && reserved_op)
        fw_read_data32 <= '0;
      else
        fw_read_data32 <= '0;
    end
  end

  fw_ip2_bxclk_gen u_bxclk_gen (
    .clk       (fw_pl_clk1),
    .rst       (srst),
    .period    (config_static_0[PERIOD_LSB +: PERIOD_W]),
    .delay     (config_static_0[DELAY_LSB +: DELAY_W]),
    .sign      (config_static_0[SIGN_BIT]),
    .bxclk_ana (fw_bxclk_ana),
    .bxclk     (fw_bxclk),
    .run       (run)
  );

endmodule

// File: tb/tb_fw_ip2_core.sv
// Randomised self-checking bench for fw_ip2_core against a time-since-load reference model.
module tb_fw_ip2_core;

  logic        clk = 1'b0;
  logic        rst, en, w_reset, w_cfg, r_cfg, w_arr0, r_arr0, w_arr1, r_arr1;
  logic        r_dat0, r_dat1, w_exec, r_status;
  logic [23:0] wdata;
  logic [31:0] read_data, status;
  logic        sps, cfg_clk, reset_not, cfg_in, cfg_load, ana, bx, trig, scan_in, scan_load;
  logic        cfg_out, scan_out, dnn0, dnn1, toggle;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cfg_model = '0;

  always #5 clk = ~clk;

  fw_ip2_core dut (
    .fw_pl_clk1(clk), .fw_rst(rst), .fw_dev_id_enable(en), .fw_op_code_w_reset(w_reset),
    .fw_op_code_w_cfg_static_0(w_cfg), .fw_op_code_r_cfg_static_0(r_cfg),
    .fw_op_code_w_cfg_array_0(w_arr0), .fw_op_code_r_cfg_array_0(r_arr0),
    .fw_op_code_w_cfg_array_1(w_arr1), .fw_op_code_r_cfg_array_1(r_arr1),
    .fw_op_code_r_data_array_0(r_dat0), .fw_op_code_r_data_array_1(r_dat1),
    .fw_op_code_w_execute(w_exec), .fw_op_code_r_status(r_status),
    .sw_write24_0(wdata), .fw_read_data32(read_data), .fw_read_status32(status),
    .fw_super_pixel_sel(sps), .fw_config_clk(cfg_clk), .fw_reset_not(reset_not),
    .fw_config_in(cfg_in), .fw_config_load(cfg_load), .fw_bxclk_ana(ana), .fw_bxclk(bx),
    .fw_vin_test_trig_out(trig), .fw_scan_in(scan_in), .fw_scan_load(scan_load),
    .fw_config_out(cfg_out), .fw_scan_out(scan_out), .fw_dnn_output_0(dnn0),
    .fw_dnn_output_1(dnn1), .fw_dn_event_toggle(toggle)
  );

  // Reference model: m = edges since the config edge. ana is high floor(P/2) cycles
  // starting 2 edges after the load; bxclk is the same waveform shifted by min(D, P/2).
  function automatic bit exp_ana(int p, int m);
    if (p < 2 || m < 2) return 1'b0;
    return ((m - 2) % p) < (p / 2);
  endfunction

  function automatic bit exp_bx(int p, int d, int s, int m);
    int deff, ph;
    if (p < 2 || m < 2) return 1'b0;
    deff = (d < p / 2) ? d : p / 2;
    ph   = s ? (m - 2 + deff) : (m - 2 - deff);
    if (ph < 0) return 1'b0;
    return (ph % p) < (p / 2);
  endfunction

  function automatic int fp(logic [31:0] c); return int'(c[5:0]);  endfunction
  function automatic int fd(logic [31:0] c); return int'(c[10:6]); endfunction
  function automatic int fs(logic [31:0] c); return int'(c[11]);   endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_ops();
    w_reset = 0; w_cfg = 0; r_cfg = 0; w_arr0 = 0; r_arr0 = 0; w_arr1 = 0; r_arr1 = 0;
    r_dat0 = 0; r_dat1 = 0; w_exec = 0; r_status = 0;
  endtask

  task automatic write_cfg(input logic [23:0] v);
    en = 1; w_cfg = 1; wdata = v;
    step();
    w_cfg = 0;
    cfg_model = {8'h00, v};
  endtask

  task automatic hard_reset(input int n);
    rst = 1; step_n(n); rst = 0; step();
    cfg_model = '0;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    int n;
    n = $urandom_range(1, 5);
    rst = 1;
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if ({reset_not, ana, bx, sps, read_data} !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got rn=%b ana=%b bx=%b sps=%b rd=%h want all 0",
                 i, reset_not, ana, bx, sps, read_data);
      end
    end
    rst = 0;
    step();
    checks++;
    if (reset_not !== 1'b1 || read_data !== 32'h0 ||
        {cfg_clk, cfg_in, cfg_load, trig, scan_in, scan_load} !== 6'h0) begin
      errors++;
      $display("FAIL reset_release got rn=%b rd=%h pins=%b want rn=1 rd=0 pins=0", reset_not,
               read_data, {cfg_clk, cfg_in, cfg_load, trig, scan_in, scan_load});
    end
    cfg_model = '0;
  endtask

  task automatic test_bxclk_directed();
    logic [23:0] vals [2];
    vals[0] = 24'h00008A;
    vals[1] = 24'h00088A;
    for (int k = 0; k < 2; k++) begin
      hard_reset(1);
      write_cfg(vals[k]);
      for (int m = 1; m <= 34; m++) begin
        step();
        checks++;
        if (ana !== exp_ana(10, m) || bx !== exp_bx(10, 2, k, m)) begin
          errors++;
          $display("FAIL bxclk_directed cfg=%h m=%0d got ana=%b bx=%b want ana=%b bx=%b",
                   vals[k], m, ana, bx, exp_ana(10, m), exp_bx(10, 2, k, m));
        end
      end
    end
  endtask

  task automatic test_bxclk_random();
    logic [23:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 24'($urandom) & 24'h001FC0;
      v[5:0] = 6'($urandom_range(2, 63));
      hard_reset(1);
      write_cfg(v);
      for (int m = 1; m <= 2 * fp(cfg_model) + 6; m++) begin
        step();
        checks++;
        if (ana !== exp_ana(fp(cfg_model), m) ||
            bx !== exp_bx(fp(cfg_model), fd(cfg_model), fs(cfg_model), m)) begin
          errors++;
          $display("FAIL bxclk_random cfg=%h m=%0d got ana=%b bx=%b want ana=%b bx=%b", v, m,
                   ana, bx, exp_ana(fp(cfg_model), m),
                   exp_bx(fp(cfg_model), fd(cfg_model), fs(cfg_model), m));
        end
      end
    end
  endtask

  task automatic test_read_back();
    hard_reset(1);
    write_cfg(24'h00108A);
    r_cfg = 1;
    step();
    r_cfg = 0;
    checks++;
    if (read_data !== 32'h0000108A || sps !== 1'b1 || status[0] !== 1'b1) begin
      errors++;
      $display("FAIL read_back got rd=%h sps=%b run=%b want rd=0000108a sps=1 run=1",
               read_data, sps, status[0]);
    end
    step();
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL read_idle got %h want 0", read_data);
    end
  endtask

  task automatic test_status();
    logic [4:0]  pins;
    logic [31:0] want;
    for (int k = 0; k < 4; k++) begin
      pins = 5'($urandom);
      {toggle, dnn1, dnn0, scan_out, cfg_out} = pins;
      step_n(2);
      want = {26'h0, pins, fp(cfg_model) >= 2};
      checks++;
      if (status !== want) begin
        errors++;
        $display("FAIL status got %h want %h", status, want);
      end
      en = 1; r_status = 1;
      step();
      checks++;
      if (read_data !== want) begin
        errors++;
        $display("FAIL read_status got %h want %h", read_data, want);
      end
      r_cfg = 1;
      step();
      checks++;
      if (read_data !== cfg_model) begin
        errors++;
        $display("FAIL read_priority got %h want %h", read_data, cfg_model);
      end
      idle_ops();
    end
    r_arr0 = 1; r_dat1 = 1;
    step();
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL reserved_read got %h want 0", read_data);
    end
    idle_ops();
  endtask

  task automatic test_dev_id_gate();
    en = 0; w_cfg = 1; wdata = 24'($urandom) | 24'h000004;
    step();
    w_cfg = 0; r_cfg = 1;
    step();
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL gated_read got %h want 0", read_data);
    end
    en = 1;
    step();
    r_cfg = 0;
    checks++;
    if (read_data !== cfg_model) begin
      errors++;
      $display("FAIL gated_write got %h want %h", read_data, cfg_model);
    end
  endtask

  task automatic test_small_period();
    for (int p = 0; p < 2; p++) begin
      write_cfg((24'($urandom) & 24'h000FC0) | 24'(p));
      for (int m = 1; m <= 12; m++) begin
        step();
        checks++;
        if (ana !== 1'b0 || bx !== 1'b0 || status[0] !== 1'b0) begin
          errors++;
          $display("FAIL small_period P=%0d m=%0d got ana=%b bx=%b run=%b want 0 0 0", p, m,
                   ana, bx, status[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old_cfg;
    logic [23:0] v;
    int          p, d, s, n0;
    hard_reset(1);
    write_cfg(24'h00050C);
    old_cfg = cfg_model;
    n0 = $urandom_range(3, 9);
    step_n(n0 - 1);
    // Rewriting the same value for several cycles must not restart the clocks.
    w_cfg = 1; wdata = old_cfg[23:0];
    for (int m = n0; m < n0 + 20; m++) begin
      step();
      if (m == n0 + 3) w_cfg = 0;
      checks++;
      if (ana !== exp_ana(12, m) || bx !== exp_bx(12, 20, 0, m)) begin
        errors++;
        $display("FAIL held_write m=%0d got ana=%b bx=%b want ana=%b bx=%b", m, ana, bx,
                 exp_ana(12, m), exp_bx(12, 20, 0, m));
      end
    end
    for (int k = 0; k < 4; k++) begin
      old_cfg = cfg_model;
      v = 24'($urandom) & 24'h001FC0;
      v[5:0] = 6'($urandom_range(2, 40));
      w_cfg = 1; r_cfg = 1; wdata = v;
      step();
      w_cfg = 0; r_cfg = 0;
      cfg_model = {8'h00, v};
      p = fp(cfg_model); d = fd(cfg_model); s = fs(cfg_model);
      checks++;
      if (read_data !== old_cfg) begin
        errors++;
        $display("FAIL write_read_same_cycle got %h want %h", read_data, old_cfg);
      end
      for (int m = 1; m <= 2 * p + 4; m++) begin
        step();
        if (m >= 2) begin
          checks++;
          if (ana !== exp_ana(p, m) || bx !== exp_bx(p, d, s, m)) begin
            errors++;
            $display("FAIL midrun_change cfg=%h m=%0d got ana=%b bx=%b want ana=%b bx=%b", v,
                     m, ana, bx, exp_ana(p, m), exp_bx(p, d, s, m));
          end
        end
      end
    end
  endtask

  task automatic test_soft_reset();
    write_cfg(24'h00108A);
    step_n(7);
    en = 1; w_reset = 1;
    step();
    w_reset = 0;
    cfg_model = '0;
    checks++;
    if (reset_not !== 1'b0 || ana !== 1'b0 || bx !== 1'b0 || sps !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset got rn=%b ana=%b bx=%b sps=%b want 0 0 0 0", reset_not, ana,
               bx, sps);
    end
    r_cfg = 1;
    step();
    r_cfg = 0;
    checks++;
    if (reset_not !== 1'b1 || read_data !== 32'h0) begin
      errors++;
      $display("FAIL soft_reset_release got rn=%b rd=%h want rn=1 rd=0", reset_not, read_data);
    end
    for (int m = 0; m < 12; m++) begin
      step();
      checks++;
      if (ana !== 1'b0 || bx !== 1'b0) begin
        errors++;
        $display("FAIL soft_reset_stopped m=%0d got ana=%b bx=%b want 0 0", m, ana, bx);
      end
    end
  endtask

  initial begin
    rst = 1; en = 0; wdata = '0;
    idle_ops();
    {toggle, dnn1, dnn0, scan_out, cfg_out} = '0;
    test_reset();
    test_bxclk_directed();
    test_bxclk_random();
    test_read_back();
    test_status();
    test_dev_id_gate();
    test_small_period();
    test_back_to_back();
    test_soft_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
